// File: rtl/apple1_kbd_pkg.sv
// Shared constants and the byte translation used by the keyboard arbiter.
package apple1_kbd_pkg;

    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_CASE_OFS = 8'h20;
    localparam logic [7:0] KBD_BIT7       = 8'h80;

    localparam int SRC_PS2  = 0;
    localparam int SRC_UART = 1;

    typedef struct packed {
        logic       drop;
        logic [7:0] data;
    } kbd_xlat_t;

    // 7-bit ASCII, optional lower-to-upper fold; LF is flagged so it never reaches the CPU.
    function automatic kbd_xlat_t kbd_translate(input logic [7:0] raw, input logic fold);
        kbd_xlat_t  r;
        logic [7:0] b;
        b = raw & ~KBD_BIT7;
        r.drop = (b == ASCII_LF);
        if (fold && (b >= 8'h61) && (b <= 8'h7A)) begin
            b = b - ASCII_CASE_OFS;
        end
        r.data = b;
        return r;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous character FIFO with count-based full/empty and a synchronous clear.
module kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk25,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is read asynchronously so the holder can load it in the same cycle it is popped.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk25) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/kbd_arbiter.sv
// Merges PS/2 and UART ASCII streams into one buffered keyboard register for the PIA.
module kbd_arbiter
    import apple1_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CASE_UPPER = 1
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       flush,
    input  logic [1:0] src_en,
    input  logic       ps2_valid,
    input  logic [7:0] ps2_data,
    output logic       ps2_ready,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    output logic       uart_ready,
    input  logic       kbd_rd,
    output logic [7:0] kbd_data,
    output logic       kbd_avail
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       room;
    logic       accept;
    logic       push;
    logic       pop;
    logic [7:0] raw_byte;
    kbd_xlat_t  xlat;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic       ps2_turn_reg;
    logic       avail_reg;
    logic [7:0] data_reg;

    assign req[SRC_PS2]  = src_en[SRC_PS2] & ps2_valid;
    assign req[SRC_UART] = src_en[SRC_UART] & uart_valid;

    // Room depends only on registered count, flush and reset, never on kbd_rd.
    assign room = ~fifo_full & ~flush & ~rst;

    always_comb begin
        grant = '0;
        if (req[SRC_PS2] && (!req[SRC_UART] || ps2_turn_reg)) begin
            grant[SRC_PS2] = 1'b1;
        end else if (req[SRC_UART]) begin
            grant[SRC_UART] = 1'b1;
        end
    end

    // Disabled sources are drained unconditionally so they never stall upstream.
    assign ps2_ready  = src_en[SRC_PS2]  ? (room & grant[SRC_PS2])  : 1'b1;
    assign uart_ready = src_en[SRC_UART] ? (room & grant[SRC_UART]) : 1'b1;

    assign accept   = room & (|grant);
    assign raw_byte = grant[SRC_UART] ? uart_data : ps2_data;
    assign xlat     = kbd_translate(raw_byte, CASE_UPPER != 0);
    assign push     = accept & ~xlat.drop;
    assign pop      = ~avail_reg & ~fifo_empty & ~flush;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk25   (clk25),
        .rst     (rst),
        .clr     (flush),
        .push    (push),
        .wr_data (xlat.data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk25) begin
        if (rst) begin
            ps2_turn_reg <= 1'b1;
        end else if (accept) begin
            ps2_turn_reg <= grant[SRC_UART];
        end
    end

    // Holder only reloads while empty, leaving one idle cycle between back-to-back characters.
    always_ff @(posedge clk25) begin
        if (rst) begin
            avail_reg <= 1'b0;
            data_reg  <= KBD_BIT7;
        end else if (flush) begin
            avail_reg <= 1'b0;
        end else if (pop) begin
            avail_reg <= 1'b1;
            data_reg  <= fifo_rd_data | KBD_BIT7;
        end else if (kbd_rd && avail_reg) begin
            avail_reg <= 1'b0;
        end
    end

    assign kbd_data  = data_reg;
    assign kbd_avail = avail_reg;

endmodule

// File: tb/tb_kbd_arbiter.sv
// Directed and random checks of kbd_arbiter against a queue-based keyboard model.
module tb_kbd_arbiter;

    localparam int DEPTH = 4;
    localparam int CU    = 1;

    logic       clk25 = 1'b0;
    logic       rst, flush, ps2_valid, uart_valid, kbd_rd;
    logic [1:0] src_en;
    logic [7:0] ps2_data, uart_data, kbd_data;
    logic       ps2_ready, uart_ready, kbd_avail;

    always #20 clk25 = ~clk25;

    kbd_arbiter #(.FIFO_DEPTH(DEPTH), .CASE_UPPER(CU)) dut (
        .clk25      (clk25),
        .rst        (rst),
        .flush      (flush),
        .src_en     (src_en),
        .ps2_valid  (ps2_valid),
        .ps2_data   (ps2_data),
        .ps2_ready  (ps2_ready),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .kbd_rd     (kbd_rd),
        .kbd_data   (kbd_data),
        .kbd_avail  (kbd_avail)
    );

    int total = 0;
    int bad   = 0;

    // Model: characters waiting (bit7 set), the holder, and whose turn it is on contention.
    logic [7:0] q[$];
    logic [7:0] rd_log[$];
    logic       m_avail = 1'b0;
    logic [7:0] m_data  = 8'h80;
    logic       m_ps2_turn = 1'b1;
    logic       o_ps2_r, o_uart_r;
    int         idx;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive, check readys against the model, clock, update model, check outputs.
    task automatic cycle(input logic r, input logic f, input logic [1:0] en,
                         input logic pv, input logic [7:0] pd,
                         input logic uv, input logic [7:0] ud, input logic rd);
        logic       can, gp, gu;
        logic [7:0] b;
        rst = r; flush = f; src_en = en;
        ps2_valid = pv; ps2_data = pd; uart_valid = uv; uart_data = ud; kbd_rd = rd;
        #2;
        can = !r && !f && (q.size() < DEPTH);
        gp  = en[0] && pv && (!(en[1] && uv) || m_ps2_turn);
        gu  = en[1] && uv && !gp;
        o_ps2_r  = ps2_ready;
        o_uart_r = uart_ready;
        chk1("ps2_ready", ps2_ready, en[0] ? (can && gp) : 1'b1);
        chk1("uart_ready", uart_ready, en[1] ? (can && gu) : 1'b1);
        if (rd && kbd_avail) rd_log.push_back(kbd_data);
        @(posedge clk25);
        if (r) begin
            q.delete();
            m_avail = 1'b0;
            m_data = 8'h80;
            m_ps2_turn = 1'b1;
        end else if (f) begin
            q.delete();
            m_avail = 1'b0;
        end else begin
            if (!m_avail && q.size() > 0) begin
                m_data = q.pop_front();
                m_avail = 1'b1;
            end else if (m_avail && rd) begin
                m_avail = 1'b0;
            end
            if (can && (gp || gu)) begin
                b = (gu ? ud : pd) & 8'h7F;
                if (b != 8'h0A) begin
                    if (CU != 0 && b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
                    q.push_back(b | 8'h80);
                end
                m_ps2_turn = gu;
            end
        end
        #1;
        chk1("kbd_avail", kbd_avail, m_avail);
        chk8("kbd_data", kbd_data, m_data);
    endtask

    task automatic drain(input logic [1:0] en);
        for (int c = 0; c < 40 && (m_avail || q.size() > 0); c++) begin
            cycle(1'b0, 1'b0, en, 1'b0, 8'h00, 1'b0, 8'h00, m_avail);
        end
    endtask

    initial begin
        // Reset state
        cycle(1'b1, 1'b0, 2'b11, 1'b1, 8'h41, 1'b1, 8'h42, 1'b0);
        chk1("rst_ps2_ready", o_ps2_r, 1'b0);
        chk1("rst_uart_ready", o_uart_r, 1'b0);
        chk8("rst_data", kbd_data, 8'h80);
        chk1("rst_avail", kbd_avail, 1'b0);

        // Single lowercase PS/2 byte, latency and case folding
        cycle(1'b0, 1'b0, 2'b11, 1'b1, 8'h61, 1'b0, 8'h00, 1'b0);
        chk1("single_ready", o_ps2_r, 1'b1);
        chk1("single_avail_n", kbd_avail, 1'b0);
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk1("single_avail_n1", kbd_avail, 1'b1);
        chk8("single_data", kbd_data, 8'hC1);
        drain(2'b11);

        // Round-robin with both sources valid every cycle
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 2'b11, 1'b1, 8'h41, 1'b1, 8'h42, 1'b0);
            chk1("rr_ps2", o_ps2_r, (i % 2) == 0);
            chk1("rr_uart", o_uart_r, (i % 2) == 1);
        end
        rd_log.delete();
        drain(2'b11);
        chki("rr_reads", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            chk8("rr_order", rd_log[i], (i % 2 == 0) ? 8'hC1 : 8'hC2);

        // Fill to capacity with no reads, then drain
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 8'(8'h31 + idx), 1'b0);
            if (o_uart_r) idx++;
        end
        chki("full_accepted", idx, 5);
        chk1("full_stall", o_uart_r, 1'b0);
        chk8("full_holder", kbd_data, 8'hB1);
        rd_log.delete();
        for (int c = 0; c < 40 && (idx < 6 || m_avail || q.size() > 0); c++) begin
            cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'h00, idx < 6, 8'(8'h31 + idx), m_avail);
            if (o_uart_r && idx < 6) idx++;
        end
        chki("full_reads", rd_log.size(), 6);
        for (int i = 0; i < 6 && i < rd_log.size(); i++)
            chk8("full_order", rd_log[i], 8'(8'hB1 + i));

        // LF dropped, CR delivered
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 8'h0A, 1'b0);
        chk1("lf_ready", o_uart_r, 1'b1);
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 8'h0D, 1'b0);
        chk1("cr_ready", o_uart_r, 1'b1);
        rd_log.delete();
        drain(2'b11);
        chki("lfcr_reads", rd_log.size(), 1);
        if (rd_log.size() > 0) chk8("lfcr_data", rd_log[0], 8'h8D);

        // Flush with three buffered, simultaneous read and UART valid
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 8'(8'h41 + i), 1'b0);
        cycle(1'b0, 1'b1, 2'b11, 1'b0, 8'h00, 1'b1, 8'h45, 1'b1);
        chk1("flush_uart_ready", o_uart_r, 1'b0);
        chk1("flush_avail", kbd_avail, 1'b0);
        chk8("flush_data", kbd_data, 8'hC1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            chk1("flush_empty", kbd_avail, 1'b0);
        end

        // Disabled UART is drained silently; reset mid-stream
        cycle(1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
            chk1("dis_uart_ready", o_uart_r, 1'b1);
            chk1("dis_no_avail", kbd_avail, 1'b0);
        end
        cycle(1'b0, 1'b0, 2'b01, 1'b1, 8'h50, 1'b1, 8'h55, 1'b0);
        cycle(1'b0, 1'b0, 2'b01, 1'b1, 8'h51, 1'b1, 8'h55, 1'b0);
        cycle(1'b1, 1'b0, 2'b01, 1'b1, 8'h52, 1'b1, 8'h55, 1'b0);
        chk1("midrst_uart_ready", o_uart_r, 1'b1);
        chk8("midrst_data", kbd_data, 8'h80);
        chk1("midrst_avail", kbd_avail, 1'b0);
        cycle(1'b0, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk1("midrst_discard", kbd_avail, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            logic [7:0] pd, ud;
            pd = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            ud = ($urandom_range(0, 7) == 0) ? 8'h8A : 8'($urandom_range(8'h5E, 8'h7F));
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0,
                  ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11,
                  1'($urandom), pd, 1'($urandom), ud, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
